pll_lock_supervisor: RTL and testbench

Supervises the video PLL's `pll_lock` output and sequences resets for the LED pipeline. It runs on the free-running 148.5 MHz reference clock that also feeds the PLL's `clkin1`. It drives the PLL's `RST` input, and holds downstream logic in the PLL output domains in reset until lock has been stable for a programmable time. On lock loss or a lock timeout it resets and retries the PLL.

---
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock supervisor and downstream reset sequencer
// Optional retry counter port enabled by PLL_LOCK_SUPERVISOR_RETRY_CNT_EN.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 148500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       rst_out_n,
  output logic       locked,
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
  output logic       lock_lost,
  output logic [7:0] retry_cnt
`else
  output logic       lock_lost
`endif
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          lock_m, lock_s;
  logic          pll_rst_d, run_d, lost_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RESET_PLL: if (cnt == RST_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s)                     state_next = STABLE;
        else if (cnt == TIMEOUT_LAST)   state_next = RESET_PLL;
      end
      STABLE: begin
        if (!lock_s)                    state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST)    state_next = RUN;
      end
      RUN:     if (!lock_s) state_next = RESET_PLL;
      default: state_next = RESET_PLL;
    endcase
  end

  always_comb begin
    pll_rst_d = (state_next == RESET_PLL);
    run_d     = (state_next == RUN);
    lost_d    = (state == RUN) && (state_next == RESET_PLL);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out_n <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= (state_next != state) ? '0 : cnt + CW'(1);
      pll_rst   <= pll_rst_d;
      rst_out_n <= run_d;
      locked    <= run_d;
      lock_lost <= lost_d;
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
  logic retry_inc;

  always_comb begin
    retry_inc = (state_next == RESET_PLL) && ((state == WAIT_LOCK) || (state == RUN));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_cnt <= 8'd0;
    end else if (retry_inc && (retry_cnt != 8'hFF)) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       pll_rst;
  logic       rst_out_n;
  logic       locked;
  logic       lock_lost;
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
  logic [7:0] retry_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pll_lock (pll_lock),
    .pll_rst  (pll_rst),
    .rst_out_n(rst_out_n),
    .locked   (locked),
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
`else
    .lock_lost(lock_lost)
`endif
  );

  task automatic check(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},   0, pll_rst,   1);
    check({tag, "_rst_out_n"}, 0, rst_out_n, 0);
    check({tag, "_locked"},    0, locked,    0);
    check({tag, "_lock_lost"}, 0, lock_lost, 0);
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
    check({tag, "_retry_cnt"}, 0, retry_cnt, 0);
`endif
  endtask

  // Second run: glitch after edges 10-11, loss after edge 25, lock returns after edge 9421.
  function automatic logic lock_after(input int e);
    if (e == 10 || e == 11) return 1'b0;
    if (e >= 25 && e < 9421) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_rst2(input int e);
    if (e < 4)    return 1'b1;
    if (e < 28)   return 1'b0;
    if (e < 9424) return ((e - 28) % 36) < 4;
    return 1'b0;
  endfunction

  function automatic logic exp_run2(input int e);
    return (e >= 23 && e < 28) || (e >= 9432);
  endfunction

  function automatic int exp_retry2(input int e);
    int r;
    if (e < 28) return 0;
    r = 1 + (e - 28) / 36;
    return (r > 255) ? 255 : r;
  endfunction

  initial begin
    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    sys_rst_n = 1'b1;

    // Clean lock: pll_lock rises after edge 10, STABLE at 13, RUN at 21.
    for (int e = 1; e <= 25; e++) begin
      step();
      check("p1_pll_rst",   e, pll_rst,   (e < 4));
      check("p1_rst_out_n", e, rst_out_n, (e >= 21));
      check("p1_locked",    e, locked,    (e >= 21));
      check("p1_lock_lost", e, lock_lost, 0);
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
      check("p1_retry_cnt", e, retry_cnt, 0);
`endif
      if (e == 10) pll_lock = 1'b1;
    end

    // Asynchronous reset pulse between clock edges while in RUN.
    #1 sys_rst_n = 1'b0;
    #1 check_reset_values("async");
    #1 sys_rst_n = 1'b1;

    // Restart with lock held, glitch in STABLE, loss in RUN, repeated timeouts, late lock.
    for (int e = 1; e <= 9435; e++) begin
      step();
      check("p2_pll_rst",   e, pll_rst,   exp_rst2(e));
      check("p2_rst_out_n", e, rst_out_n, exp_run2(e));
      check("p2_locked",    e, locked,    exp_run2(e));
      check("p2_lock_lost", e, lock_lost, (e == 28));
`ifdef PLL_LOCK_SUPERVISOR_RETRY_CNT_EN
      check("p2_retry_cnt", e, retry_cnt, exp_retry2(e));
`endif
      pll_lock = lock_after(e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
